// File: rtl/sc_pkg.sv
// sc_pkg: shared state encoding and width helpers for the stochastic stream decoder.
package sc_pkg;

    typedef enum logic [1:0] {IDLE, FLUSH, COUNT, DONE} state_t;

    function automatic int count_width(input int win_log2);
        return win_log2 + 1;
    endfunction

    localparam int DEF_WIN_LOG2   = 8;
    localparam int DEF_SCALE_LOG2 = 4;
    localparam int SUM_WIDTH      = count_width(DEF_WIN_LOG2) + DEF_SCALE_LOG2;

endpackage

// File: rtl/sc_window_counter.sv
// sc_window_counter: enabled up-counter whose tc flags the enable that consumes the LIMIT-th event.
module sc_window_counter #(
    parameter int LIMIT = 4,
    parameter int W     = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign tc = en && (cnt == LAST);

endmodule

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: counts ones in a 2^WIN_LOG2 window of a unipolar stochastic stream after
// skipping SKIP fill bits, and presents raw and rescaled counts on a valid/ready output.
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int WIN_LOG2   = DEF_WIN_LOG2,
    parameter int SCALE_LOG2 = DEF_SCALE_LOG2,
    parameter int SKIP       = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic                                         bit_in,
    input  logic                                         bit_valid,
    output logic                                         busy,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [count_width(WIN_LOG2)-1:0]             out_count,
    output logic [count_width(WIN_LOG2)+SCALE_LOG2-1:0]  out_sum
);

    localparam int CW = count_width(WIN_LOG2);
    localparam int SW = CW + SCALE_LOG2;

    state_t        state, next;
    logic          go, skip_en, skip_tc, win_en, win_tc;
    logic [CW-1:0] ones, ones_nxt;

    assign go       = (state == IDLE) && start;
    assign skip_en  = (state == FLUSH) && bit_valid;
    assign win_en   = (state == COUNT) && bit_valid;
    assign ones_nxt = ones + CW'(bit_in);

    sc_window_counter #(.LIMIT(SKIP)) u_skip (
        .clk(clk), .rst(rst), .clr(go), .en(skip_en), .tc(skip_tc)
    );

    sc_window_counter #(.LIMIT(1 << WIN_LOG2), .W(CW)) u_window (
        .clk(clk), .rst(rst), .clr(go), .en(win_en), .tc(win_tc)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = go ? ((SKIP > 0) ? FLUSH : COUNT) : IDLE;
            FLUSH:   next = skip_tc ? COUNT : FLUSH;
            COUNT:   next = win_tc ? DONE : COUNT;
            DONE:    next = out_ready ? IDLE : DONE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || go)
            ones <= '0;
        else if (win_en)
            ones <= ones_nxt;
    end

    // Result registers capture the final bit too, and hold across the handshake until the next result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_count <= '0;
            out_sum   <= '0;
        end else if (win_tc) begin
            out_count <= ones_nxt;
            out_sum   <= SW'(ones_nxt) << SCALE_LOG2;
        end
    end

    assign busy      = state != IDLE;
    assign out_valid = state == DONE;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb_sc_stream_decoder: directed checks of the default decoder and a SKIP=0, WIN_LOG2=2 instance.
module tb_sc_stream_decoder;

    logic        clk = 0;
    logic        rst = 0;
    logic        start = 0, bit_in = 0, bit_valid = 0, out_ready = 0;
    logic        busy, out_valid;
    logic [8:0]  out_count;
    logic [12:0] out_sum;

    logic        start2 = 0, bit2 = 0, valid2 = 0, ready2 = 0;
    logic        busy2, out_valid2;
    logic [2:0]  out_count2;
    logic [6:0]  out_sum2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sc_stream_decoder dut (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_sum(out_sum)
    );

    sc_stream_decoder #(.WIN_LOG2(2), .SCALE_LOG2(4), .SKIP(0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bit_in(bit2), .bit_valid(valid2),
        .busy(busy2), .out_valid(out_valid2), .out_ready(ready2),
        .out_count(out_count2), .out_sum(out_sum2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic feed(input logic b);
        bit_in = b;
        bit_valid = 1;
        tick();
        bit_valid = 0;
    endtask

    task automatic handshake();
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int vld;
        int gaps;
        logic early;

        rst = 1;
        tick();
        tick();
        rst = 0;
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_count", out_count, 0);
        check("rst_sum", out_sum, 0);
        check("rst_valid2", out_valid2, 0);

        // All-ones window: result visible exactly 1+4+256 cycles after start.
        pulse_start();
        check("busy_after_start", busy, 1);
        for (int i = 0; i < 4; i++) feed(0);
        for (int i = 0; i < 255; i++) feed(1);
        check("ones_not_early", out_valid, 0);
        feed(1);
        check("ones_valid", out_valid, 1);
        check("ones_count", out_count, 256);
        check("ones_sum", out_sum, 4096);
        handshake();
        check("ones_hs_valid", out_valid, 0);
        check("ones_hs_busy", busy, 0);
        check("ones_hold_count", out_count, 256);

        // Skip isolation: skipped ones are not counted.
        pulse_start();
        for (int i = 0; i < 4; i++) feed(1);
        for (int i = 0; i < 256; i++) feed((i % 2) == 0);
        check("skip_valid", out_valid, 1);
        check("skip_count", out_count, 128);
        check("skip_sum", out_sum, 2048);
        handshake();

        // Valid gaps every third cycle, including within FLUSH.
        pulse_start();
        vld = 0;
        gaps = 0;
        early = 0;
        for (int c = 0; c < 1000 && vld < 259; c++) begin
            if (c % 3 == 2) begin
                tick();
                gaps++;
            end else begin
                feed(vld >= 4);
                vld++;
            end
            early = early | out_valid;
        end
        check("gap_count_gaps", gaps, 129);
        check("gap_not_early", early, 0);
        tick();
        check("gap_stall_valid", out_valid, 0);
        feed(1);
        check("gap_valid", out_valid, 1);
        check("gap_count", out_count, 256);

        // Backpressure with a start pulse during DONE.
        for (int i = 0; i < 20; i++) begin
            start = (i == 5);
            bit_valid = 1;
            bit_in = 0;
            tick();
        end
        start = 0;
        bit_valid = 0;
        check("bp_valid", out_valid, 1);
        check("bp_count", out_count, 256);
        check("bp_sum", out_sum, 4096);
        start = 1;
        out_ready = 1;
        tick();
        start = 0;
        out_ready = 0;
        check("bp_hs_valid", out_valid, 0);
        check("bp_hs_busy", busy, 0);
        for (int i = 0; i < 5; i++) feed(1);
        check("bp_stay_idle", busy, 0);
        check("bp_idle_count", out_count, 256);

        // Reset mid-COUNT, then an all-zero window.
        pulse_start();
        for (int i = 0; i < 4; i++) feed(1);
        for (int i = 0; i < 100; i++) feed(1);
        rst = 1;
        tick();
        rst = 0;
        check("rstc_busy", busy, 0);
        check("rstc_valid", out_valid, 0);
        check("rstc_count", out_count, 0);
        pulse_start();
        for (int i = 0; i < 260; i++) feed(0);
        check("zero_valid", out_valid, 1);
        check("zero_count", out_count, 0);
        check("zero_sum", out_sum, 0);
        handshake();

        // SKIP=0, WIN_LOG2=2: first bit after start is counted.
        start2 = 1;
        tick();
        start2 = 0;
        check("s0_busy", busy2, 1);
        valid2 = 1;
        bit2 = 1; tick();
        bit2 = 0; tick();
        bit2 = 1; tick();
        check("s0_not_early", out_valid2, 0);
        bit2 = 1; tick();
        valid2 = 0;
        check("s0_valid", out_valid2, 1);
        check("s0_count", out_count2, 3);
        check("s0_sum", out_sum2, 48);
        ready2 = 1;
        tick();
        ready2 = 0;
        check("s0_hs_valid", out_valid2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
